// File: rtl/fp_sched_pkg.sv
// fp_sched_pkg: shared state encoding and field widths for the float-conversion scheduler.
package fp_sched_pkg;
    typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, OUT} state_t;
    localparam int IN_W  = 12;
    localparam int MAG_W = 11;
    localparam int E_W   = 3;
    localparam int F_W   = 4;
    localparam logic [E_W-1:0] E_MAX = 3'd7;
endpackage

// File: rtl/fp_sched_arb.sv
// fp_sched_arb: one-hot grant, searching upward from pointer+1 with wrap-around.
// A pointer held at NUM_REQ-1 turns this into fixed lowest-index priority.
module fp_sched_arb
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    input  logic                       enable,
    output logic [NUM_REQ-1:0]         grant
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW:0]          sh;
    logic [2*NUM_REQ-1:0] dbl, back;
    logic [NUM_REQ-1:0]   rot, pick;

    // Rotate so the search start sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        sh    = {1'b0, pointer} + 1'b1;
        dbl   = {req_valid, req_valid} >> sh;
        rot   = dbl[NUM_REQ-1:0];
        pick  = rot & (~rot + 1'b1);
        back  = {pick, pick} << sh;
        grant = enable ? back[2*NUM_REQ-1:NUM_REQ] : '0;
    end
endmodule

// File: rtl/fp_convert_sched.sv
// fp_convert_sched: shared multi-cycle 12-bit int to {S,E[2:0],F[3:0]} float converter.
// Define FP_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module fp_convert_sched
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [IN_W*NUM_REQ-1:0]    req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic                       out_s,
    output logic [E_W-1:0]             out_e,
    output logic [F_W-1:0]             out_f,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

    state_t          state;
    logic [IN_W-1:0]  data, neg, sel_data;
    logic [MAG_W-1:0] mag, mag_abs;
    logic [E_W-1:0]   exp_r, e_rnd;
    logic [F_W-1:0]   f_raw, f_rnd;
    logic [IW-1:0]    ptr, gnt_idx, id;
    logic [NUM_REQ-1:0] grant;
    logic             sign, r, accept;

    fp_sched_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid(req_valid),
        .pointer  (ptr),
        .enable   (state == IDLE && !rst),
        .grant    (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign busy      = state != IDLE;

    always_comb begin
        gnt_idx  = '0;
        sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) begin
                gnt_idx  = IW'(j);
                sel_data = req_data[j*IN_W +: IN_W];
            end
        end
    end

    // 12'h800 has no positive counterpart in 11 bits, so it saturates.
    assign neg     = -data;
    assign mag_abs = data == {1'b1, {MAG_W{1'b0}}} ? {MAG_W{1'b1}} :
                     data[IN_W-1] ? neg[MAG_W-1:0] : data[MAG_W-1:0];

    assign f_raw = mag[MAG_W-1 -: F_W];
    assign r     = mag[MAG_W-1-F_W];
    assign f_rnd = !r ? f_raw : !(&f_raw) ? f_raw + 1'b1 : exp_r < E_MAX ? 4'b1000 : f_raw;
    assign e_rnd = r && (&f_raw) && exp_r < E_MAX ? exp_r + 1'b1 : exp_r;

`ifdef FP_SCHED_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= PTR_RST;
        else if (accept) ptr <= gnt_idx;
    end
`else
    assign ptr = PTR_RST;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data      <= '0;
            id        <= '0;
            sign      <= 1'b0;
            mag       <= '0;
            exp_r     <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_s     <= 1'b0;
            out_e     <= '0;
            out_f     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    data  <= sel_data;
                    id    <= gnt_idx;
                    state <= ABS;
                end
                ABS: begin
                    sign  <= data[IN_W-1];
                    mag   <= mag_abs;
                    exp_r <= E_MAX;
                    state <= NORM;
                end
                NORM: if (mag[MAG_W-1] || exp_r == '0) state <= ROUND;
                      else begin
                          mag   <= mag << 1;
                          exp_r <= exp_r - 1'b1;
                      end
                ROUND: begin
                    out_s     <= sign;
                    out_e     <= e_rnd;
                    out_f     <= f_rnd;
                    out_id    <= id;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_convert_sched.sv
// tb_fp_convert_sched: scoreboard bench for fp_convert_sched (NUM_REQ=4).
module tb_fp_convert_sched;
    localparam int N = 4;

    typedef struct {
        int id;
        int s;
        int e;
        int f;
        int lat;
        int acc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready;
    logic [12*N-1:0]   req_data;
    logic              out_valid, out_ready, out_s, busy;
    logic [1:0]        out_id;
    logic [2:0]        out_e;
    logic [3:0]        out_f;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0;
    logic pv = 1'b0;

`ifdef FP_SCHED_RR_EN
    int order[5] = '{0, 1, 2, 3, 0};
`else
    int order[5] = '{0, 0, 0, 0, 0};
`endif

    fp_convert_sched #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_id   (out_id),
        .out_s    (out_s),
        .out_e    (out_e),
        .out_f    (out_f),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [11:0] d, output int s, output int e,
                                  output int f, output int lat);
        int m, n, r;
        s = int'(d[11]);
        m = d == 12'h800 ? 2047 : d[11] ? 4096 - int'(d) : int'(d);
        n = 0;
        while (n < 7 && m < 1024) begin
            m = m * 2;
            n++;
        end
        e = 7 - n;
        f = m / 128;
        r = (m / 64) % 2;
        if (r == 1) begin
            if (f < 15) f++;
            else if (e < 7) begin
                f = 8;
                e++;
            end
        end
        lat = 3 + n;
    endfunction

    task automatic send_x(input int i, input logic [11:0] d, input int s, input int e,
                          input int f, input int lat);
        exp_t x;
        bit ok = 1'b0;
        @(posedge clk); #1;
        req_valid[i] = 1'b1;
        req_data[i*12 +: 12] = d;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            ok = req_ready[i];
        end
        chk("accept", int'(ok), 1);
        if (ok) begin
            x = '{i, s, e, f, lat, cyc + 1};
            sb.push_back(x);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_data[i*12 +: 12] = ~d;
    endtask

    task automatic send(input int i, input logic [11:0] d);
        int s, e, f, lat;
        model(d, s, e, f, lat);
        send_x(i, d, s, e, f, lat);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            ok = sb.size() == 0 && !busy;
        end
        chk("idle", int'(ok), 1);
    endtask

    always @(negedge clk) begin : mon
        exp_t x;
        if (out_valid && !pv) begin
            if (sb.size() > 0) chk("latency", cyc - sb[0].acc, sb[0].lat);
            else chk("spurious", int'(out_valid), 0);
        end
        if (out_valid && out_ready && sb.size() > 0) begin
            x = sb.pop_front();
            chk("out_id", int'(out_id), x.id);
            chk("out_s", int'(out_s), x.s);
            chk("out_e", int'(out_e), x.e);
            chk("out_f", int'(out_f), x.f);
        end
        pv = out_valid;
    end

    initial begin
        logic [9:0] snap;
        bit ok;
        int idx;
        rst = 1'b1;
        out_ready = 1'b1;
        req_valid = '1;
        req_data = '0;
        #3;
        chk("rst_outs", int'({out_valid, busy, out_id, out_s, out_e, out_f}), 0);
        chk("rst_ready", int'(req_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;

        send_x(0, 12'h07D, 0, 4, 8, 7);
        wait_idle();
        send_x(1, 12'h800, 1, 7, 15, 3);
        send_x(2, 12'h00D, 0, 0, 13, 10);
        send_x(3, 12'hFFF, 1, 0, 1, 10);
        send_x(0, 12'h000, 0, 0, 0, 10);
        wait_idle();
        repeat (8) send($urandom_range(0, 3), 12'($urandom_range(0, 4095)));
        wait_idle();

        out_ready = 1'b0;
        send(2, 12'h3A5);
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            ok = out_valid;
        end
        chk("bp_valid", int'(ok), 1);
        snap = {out_id, out_s, out_e, out_f};
        @(posedge clk); #1;
        req_valid = '1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", int'({out_id, out_s, out_e, out_f}), int'(snap));
            chk("bp_valid_hold", int'(out_valid), 1);
            chk("bp_ready", int'(req_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle", int'({busy, out_valid}), 0);

        send(1, 12'h00D);
        @(posedge clk); #1;
        req_valid = '1;
        req_data = {4{12'h07D}};
        @(posedge clk); #3;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_outs", int'({out_valid, busy, out_id, out_s, out_e, out_f}), 0);
        chk("mid_rst_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int g = 0; g < 5; g++) begin
            ok = 1'b0;
            for (int k = 0; k < 60 && !ok; k++) begin
                @(negedge clk);
                ok = |req_ready;
            end
            chk("grant_seen", int'(ok), 1);
            if (ok) begin
                idx = 0;
                for (int j = 0; j < N; j++) if (req_ready[j]) idx = j;
                chk("grant_onehot", $countones(req_ready), 1);
                chk("grant_order", idx, order[g]);
                sb.push_back('{idx, 0, 4, 8, 7, cyc + 1});
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_convert_sched.md
# fp_convert_sched

Time-shared float-conversion engine for the lab-2 datapath. Accepts 12-bit two's-complement samples from up to NUM_REQ requesters, arbitrates among them, and sequences one conversion at a time. Each conversion runs through magnitude, iterative normalisation and rounding stages and produces the 8-bit float {S, E[2:0], F[3:0]}, value F·2^E. Sits between the sample sources and the display/output logic; it replaces per-source combinational converters with one multi-cycle shared unit.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a sample
- req_data  in  12·NUM_REQ  sample i at bits [12i+11:12i], two's complement
- req_ready  out  NUM_REQ  one-hot grant; accept = req_valid[i] & req_ready[i]
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_id  out  $clog2(NUM_REQ)  requester index of result
- out_s  out  1  sign
- out_e  out  3  exponent
- out_f  out  4  significand
- busy  out  1  state ≠ IDLE

## Operation
- FSM: IDLE → ABS → NORM (1..8 cycles) → ROUND → OUT → IDLE.
- IDLE: req_ready = one-hot of the winning valid requester, else 0. On accept, latch data and index; go to ABS.
- ABS: s = data[11]. mag (11 bit) = |data|. Input 12'h800 saturates to 2047. exp = 7.
- NORM, per cycle: if mag[10]=1 or exp=0 → ROUND. Otherwise mag <<= 1 (zero fill) and exp -= 1.
- ROUND: f = mag[10:7], r = mag[6].
  - r=0: keep f.
  - r=1 and f<15: f+1.
  - r=1, f=15, exp<7: f=8, exp+1.
  - r=1, f=15, exp=7: saturate to f=15, e=7.
- OUT: out_valid=1. out_* hold stable until out_ready. Handshake → IDLE.
- No accept while busy: req_ready=0 in every state except IDLE.
- Input 0 → s=0, e=0, f=0.
- Arbitration pointer updates only on accept.

## Timing
- Accept at edge A.
- n = min(leading zeros of 11-bit mag, 7).
- out_valid rises after edge A+3+n. Latency 3..10 cycles.
- Completion handshake at edge B → IDLE after B; next accept earliest at B+1.
- req_ready is combinational from state, pointer and req_valid. It is never asserted while rst=1.
- Reset values: state IDLE; out_valid, out_id, out_s, out_e, out_f, busy, req_ready = 0; RR pointer = NUM_REQ-1 (requester 0 has priority first).
- rst mid-conversion: in-flight sample discarded; outputs 0 immediately (async); no result is produced.
- req_data and req_valid changes while busy are ignored.

## Configuration
- FP_SCHED_RR_EN defined: round-robin arbitration. Search starts at pointer+1 mod NUM_REQ; on accept, pointer := granted index.
- FP_SCHED_RR_EN undefined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Package fp_sched_pkg: state enum (IDLE, ABS, NORM, ROUND, OUT), IN_W=12, MAG_W=11, E_W=3, F_W=4, E_MAX=7.
- Sub-module fp_sched_arb: the grant logic (round-robin/fixed, macro-selected). Inputs: req_valid, pointer, enable. Output: one-hot grant.
- FSM, magnitude, normaliser and rounding live in the top module.

## Test plan
- Req0 data 12'h07D (125), out_ready=1 → s=0, e=4, f=8 (round overflow); out_valid 7 cycles after accept; out_id=0.
- Req1 data 12'h800 → s=1, e=7, f=15 (saturated); latency 3.
- Data 12'h00D (13) → e=0, f=13, latency 10. Data 12'hFFF → s=1, e=0, f=1. Data 0 → all-zero result.
- All four req_valid held high, out_ready=1, FP_SCHED_RR_EN defined → grant order 0,1,2,3,0. Macro undefined → always 0.
- out_ready held low 5 cycles after out_valid → out_* stable, req_ready=0 throughout; release → handshake, IDLE next cycle.
- rst pulsed while in NORM → outputs 0 at once; after release, first grant goes to requester 0; no stale result appears.
